// File: rtl/sprite_draw_ctrl.sv
// Draw sequencer: walks a full-screen or 40x40 sprite region one pixel per clock.
// Latency: drawAck 1 cycle after accept; plot trails its ROM address by 1 cycle.
// Backpressure: none; drawReq is only sampled in IDLE and is ignored while busy.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   drawReq/Full/Clear    command request, full-screen select, black fill
//   drawMem/Slot/Row      image select, sprite x-slot code, sprite y-row code
//   pixColor              colour-mux output for the current address
//   drawAck, busy, done   accept pulse, in-progress flag, completion pulse
//   addr, memorySel       linear ROM address, latched image select
//   black                 latched clear flag
//   x, y, plot            plot coordinates and write strobe
//
// Optional feature macro: DRAW_TRANSPARENT_EN (sprite pixels with colour 000
// are not plotted).
module sprite_draw_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        drawReq,
  input  logic        drawFull,
  input  logic        drawClear,
  input  logic [4:0]  drawMem,
  input  logic [3:0]  drawSlot,
  input  logic [1:0]  drawRow,
  input  logic [2:0]  pixColor,
  output logic        drawAck,
  output logic        busy,
  output logic        done,
  output logic [14:0] addr,
  output logic [4:0]  memorySel,
  output logic        black,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        plot
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_FLUSH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        full_q;
  logic [3:0]  slot_q;
  logic [1:0]  row_sel_q;
  logic [4:0]  mem_q;
  logic        black_q;
  logic [7:0]  xbase_q;
  logic [6:0]  ybase_q;
  logic [7:0]  w_q;
  logic [6:0]  h_q;
  logic [7:0]  col_q;
  logic [6:0]  row_q;
  logic [14:0] addr_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic        plot_q;

  logic        col_last;
  logic        row_last;
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic        skip_pix;
  logic [7:0]  slot_xbase;
  logic [6:0]  row_ybase;

  assign col_last = (col_q == w_q - 8'd1);
  assign row_last = (row_q == h_q - 7'd1);

  // Widened sums so an out-of-range coordinate is visible to the clip compare.
  assign x_sum = {1'b0, xbase_q} + {1'b0, col_q};
  assign y_sum = {1'b0, ybase_q} + {1'b0, row_q};

`ifdef DRAW_TRANSPARENT_EN
  // Transparency applies to coloured sprites only; full-screen and clear draws plot everything.
  assign skip_pix = !full_q && !black_q && (pixColor == 3'b000);
`else
  logic unused_pix_color;
  assign unused_pix_color = ^pixColor;
  assign skip_pix = 1'b0;
`endif

  // Battle-slot x positions; unused codes park the sprite at the left edge.
  always_comb begin
    slot_xbase = 8'd0;
    case (slot_q)
      4'd1:    slot_xbase = 8'd36;
      4'd2:    slot_xbase = 8'd30;
      4'd3:    slot_xbase = 8'd24;
      4'd4:    slot_xbase = 8'd18;
      4'd5:    slot_xbase = 8'd12;
      4'd6:    slot_xbase = 8'd6;
      4'd8:    slot_xbase = 8'd90;
      4'd9:    slot_xbase = 8'd96;
      4'd10:   slot_xbase = 8'd102;
      4'd11:   slot_xbase = 8'd108;
      4'd12:   slot_xbase = 8'd114;
      4'd13:   slot_xbase = 8'd120;
      default: slot_xbase = 8'd0;
    endcase
  end

  assign row_ybase = (row_sel_q == 2'd1) ? 7'd30 : 7'd0;

  always_comb begin
    state_d = state_q;
    drawAck = 1'b0;
    done    = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (drawReq) state_d = S_LOAD;
      end
      S_LOAD: begin
        drawAck = 1'b1;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (col_last && row_last) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      full_q    <= 1'b0;
      slot_q    <= 4'd0;
      row_sel_q <= 2'd0;
      mem_q     <= 5'd0;
      black_q   <= 1'b0;
      xbase_q   <= 8'd0;
      ybase_q   <= 7'd0;
      w_q       <= 8'd0;
      h_q       <= 7'd0;
      col_q     <= 8'd0;
      row_q     <= 7'd0;
      addr_q    <= 15'd0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
      plot_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      plot_q  <= 1'b0;
      if (state_q == S_IDLE && drawReq) begin
        full_q    <= drawFull;
        black_q   <= drawClear;
        mem_q     <= drawMem;
        slot_q    <= drawSlot;
        row_sel_q <= drawRow;
      end
      if (state_q == S_LOAD) begin
        if (full_q) begin
          xbase_q <= 8'd0;
          ybase_q <= 7'd0;
          w_q     <= 8'd160;
          h_q     <= 7'd120;
        end else begin
          xbase_q <= slot_xbase;
          ybase_q <= row_ybase;
          w_q     <= 8'd40;
          h_q     <= 7'd40;
        end
        col_q  <= 8'd0;
        row_q  <= 7'd0;
        addr_q <= 15'd0;
      end
      if (state_q == S_SCAN) begin
        x_q    <= x_sum[7:0];
        y_q    <= y_sum[6:0];
        plot_q <= (x_sum < 9'd160) && (y_sum < 8'd120) && !skip_pix;
        if (col_last) begin
          col_q <= 8'd0;
          if (!row_last) row_q <= row_q + 7'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
        // Raster order makes row*W+col a plain running count (max 19199).
        if (!(col_last && row_last)) addr_q <= addr_q + 15'd1;
      end
    end
  end

  assign addr      = addr_q;
  assign memorySel = mem_q;
  assign black     = black_q;
  assign x         = x_q;
  assign y         = y_q;
  assign plot      = plot_q;

endmodule

// File: doc/sprite_draw_ctrl.md
# sprite_draw_ctrl

Sequencer for the VGA draw datapath. It accepts one draw command at a time: a full-screen image, a full-screen black clear, or a 40x40 sprite at a battle slot. It then walks every pixel of that region, issuing a linear ROM address and the matching plot strobe with screen coordinates one cycle later. It sits between the game FSM (command side) and the colour mux, image ROMs and VGA adapter (pixel side), and replaces ad-hoc x/y counter sequencing.

## Interface
- Parameters: none. Screen is fixed at 160x120, sprite at 40x40.
- Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces IDLE and zeroes all outputs
- drawReq  in  1  command request; sampled only in IDLE
- drawFull  in  1  1 = 160x120 region at (0,0); 0 = 40x40 sprite
- drawClear  in  1  1 = draw black (drives black)
- drawMem  in  5  image select, forwarded as memorySel
- drawSlot  in  4  sprite x-slot code
- drawRow  in  2  sprite y-row code
- pixColor  in  3  colour-mux output for the current address; used only under DRAW_TRANSPARENT_EN
- drawAck  out  1  one-cycle pulse: command accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: region complete
- addr  out  15  ROM pixel address, row*W + col
- memorySel  out  5  latched drawMem
- black  out  1  latched drawClear
- x  out  8  plot x coordinate
- y  out  7  plot y coordinate
- plot  out  1  pixel write strobe for the VGA adapter

## Operation
- States: IDLE, LOAD, SCAN, FLUSH, DONE.
- IDLE
  - If drawReq=1: latch drawFull, drawClear, drawMem, drawSlot and drawRow; pulse drawAck; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: resolve the base position and region size, clear col/row counters, go to SCAN.
  - Full: base (0,0), W=160, H=120.
  - Sprite: W=H=40. xBase comes from the slot table below. yBase is 0 for row 0, 30 for row 1, and 0 for rows 2 and 3.
  - xBase by slot: 0→0, 1→36, 2→30, 3→24, 4→18, 5→12, 6→6, 7→0, 8→90, 9→96, 10→102, 11→108, 12→114, 13→120, 14→0, 15→0.
- SCAN: each cycle
  - addr = row*W + col.
  - col increments; on col=W-1 it wraps to 0 and row increments.
  - The cycle with col=W-1 and row=H-1 issues the last address, then the FSM goes to FLUSH.
- FLUSH: the last pixel's plot is emitted; go to DONE.
- DONE: done=1; go to IDLE.
- Pixel pipeline (one register stage, matching the 1-cycle ROM latency):
  - x = xBase + col and y = yBase + row, registered from the address cycle.
  - plot = 1 the cycle after each SCAN cycle.
- Clipping: plot is forced 0 for any pixel with x≥160 or y≥120. No such pixel occurs with the tables above; clipping is a guard only.
- drawReq outside IDLE is ignored; no drawAck is issued.
- drawReq held high through DONE is accepted again on the first IDLE cycle.
- memorySel and black hold their latched values from LOAD until the next acceptance. They are not cleared in IDLE.
- Width rules
  - row*W is computed in 15 bits; maximum address is 19199.
  - xBase+col is computed in 9 bits before the clip compare.
- Reset
  - Reset in any state, including mid-SCAN: next state is IDLE.
  - plot, drawAck, done and busy are 0 from the cycle after the reset edge. The partial region is abandoned.
  - Reset values: addr=0, x=0, y=0, memorySel=0, black=0.

## Timing
- Edge E0, IDLE with drawReq=1: drawAck=1 and busy=1 during cycle 1 (LOAD).
- SCAN occupies cycles 2 .. W*H+1.
- plot is high in cycles 3 .. W*H+2; the last of these is FLUSH.
- done is high in cycle W*H+3.
- IDLE at cycle W*H+4; earliest next acceptance edge is at the end of that cycle.
- Totals: sprite is 1604 cycles from accept edge to IDLE; full screen is 19204.
- Throughput: one pixel per clock, no bubbles inside a region.

## Configuration
- DRAW_TRANSPARENT_EN
  - Defined: in sprite mode with black=0, the pixel whose pixColor (sampled in its address cycle) equals 3'b000 gets plot=0. Coordinates still advance and cycle counts are unchanged. Full-screen and clear draws plot every pixel.
  - Undefined: pixColor is ignored and every in-bounds pixel is plotted.

## Test plan
- Sprite: slot 1, row 1, drawMem=10 → drawAck at cycle 1; first plot x=36,y=30 at cycle 3; last plot x=75,y=69; exactly 1600 plots; memorySel=10; done at cycle 1603.
- Full clear: drawFull=1, drawClear=1 → black=1; addr runs 0..19199; 19200 plots covering (0,0)..(159,119); done at cycle 19203.
- Slot 13, row 1 → x spans 120..159, no clipped pixels; slot 14 → xBase 0.
- drawReq pulsed at cycle 500 of a sprite draw → no drawAck; draw completes unchanged. Held drawReq → second acceptance immediately after done.
- Reset asserted at SCAN cycle 800 → IDLE next cycle, plot/busy/done=0, no done pulse; a new request afterwards runs a full 1600-plot draw.
- With DRAW_TRANSPARENT_EN, pixColor=000 on every 4th address → 1200 plots, done still at cycle 1603. Without the macro → 1600 plots.
